// File: rtl/gray_seq_checker_if.sv
// Bus between the Gray counter side and the Gray sequence checker.
// The master drives the sampled Gray word, its valid and the sync clear;
// the slave (checker) returns the decoded word and the status outputs.
interface gray_seq_checker_if #(
  parameter int W     = 8,
  parameter int ERR_W = 16
);
  logic             clr;
  logic [W-1:0]     gray_in;
  logic             gray_vld;
  logic [W-1:0]     bin_out;
  logic             bin_vld;
  logic             err_pulse;
  logic             lost_pulse;
  logic             locked;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output clr, gray_in, gray_vld,
    input  bin_out, bin_vld, err_pulse, lost_pulse, locked, err_cnt
  );

  modport slave (
    input  clr, gray_in, gray_vld,
    output bin_out, bin_vld, err_pulse, lost_pulse, locked, err_cnt
  );
endinterface

// File: rtl/gray_seq_checker.sv
// Gray sequence checker: registers the incoming Gray word, decodes it to
// binary and verifies each valid sample is a single-step advance of the
// previous one. A small FSM tracks lock; errors are counted with saturation.
// Latency is two edges from gray_in to bin_out; one sample per clock.
module gray_seq_checker #(
  parameter int W        = 8,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 16
) (
  input logic             clk,
  input logic             rst,
  gray_seq_checker_if.slave bus
);

  localparam logic [1:0] ST_ACQUIRE = 2'b00;
  localparam logic [1:0] ST_CHECK   = 2'b01;
  localparam logic [1:0] ST_LOCKED  = 2'b10;

  localparam logic [8:0]       LOCK_VAL = 9'(LOCK_CNT);
  localparam logic [W-1:0]     ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  // Gray to binary: MSB passes through, each lower bit folds in the one above.
  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [W-1:0]     s1_gray_r;
  logic             s1_vld_r;
  logic [W-1:0]     prev_bin_r;
  logic [1:0]       state_r;
  logic [7:0]       run_r;
  logic [W-1:0]     bin_out_r;
  logic             bin_vld_r;
  logic             err_pulse_r;
  logic             lost_pulse_r;
  logic             locked_r;
  logic [ERR_W-1:0] err_cnt_r;

  logic [W-1:0]     bin_s;
  logic [W-1:0]     delta_s;
  logic             good_s;
  logic             hold_s;
  logic [1:0]       state_nxt_s;
  logic [7:0]       run_nxt_s;
  logic             locked_nxt_s;
  logic             err_s;
  logic             lost_s;
  logic [ERR_W-1:0] err_cnt_nxt_s;

  // Stage 1: capture the Gray word and its valid; clear drops the sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_gray_r <= {W{1'b0}};
      s1_vld_r  <= 1'b0;
    end else if (bus.clr) begin
      s1_vld_r  <= 1'b0;
    end else begin
      s1_vld_r <= bus.gray_vld;
      if (bus.gray_vld) begin
        s1_gray_r <= bus.gray_in;
      end
    end
  end

  // Decode the stage-1 word and classify its step against the previous sample.
  always_comb begin
    bin_s   = gray2bin(s1_gray_r);
    delta_s = bin_s - prev_bin_r;
    good_s  = (delta_s == ONE_W);
    hold_s  = (delta_s == {W{1'b0}});
  end

  // Lock FSM next state, run counter and pulse generation.
  always_comb begin
    state_nxt_s  = state_r;
    run_nxt_s    = run_r;
    locked_nxt_s = locked_r;
    err_s        = 1'b0;
    lost_s       = 1'b0;
    if (s1_vld_r) begin
      case (state_r)
        ST_ACQUIRE: begin
          state_nxt_s = ST_CHECK;
          run_nxt_s   = 8'd0;
        end
        ST_CHECK: begin
          if (good_s) begin
            if (({1'b0, run_r} + 9'd1) >= LOCK_VAL) begin
              state_nxt_s  = ST_LOCKED;
              locked_nxt_s = 1'b1;
              run_nxt_s    = 8'd0;
            end else begin
              run_nxt_s = run_r + 8'd1;
            end
          end else if (hold_s) begin
            run_nxt_s = run_r;
          end else begin
            err_s     = 1'b1;
            run_nxt_s = 8'd0;
          end
        end
        ST_LOCKED: begin
          if (good_s || hold_s) begin
            state_nxt_s = ST_LOCKED;
          end else begin
            err_s        = 1'b1;
            lost_s       = 1'b1;
            state_nxt_s  = ST_CHECK;
            locked_nxt_s = 1'b0;
            run_nxt_s    = 8'd0;
          end
        end
        default: begin
          state_nxt_s  = ST_ACQUIRE;
          locked_nxt_s = 1'b0;
          run_nxt_s    = 8'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Saturating increment of the error count.
  always_comb begin
    if (err_s && (err_cnt_r != ERR_MAX)) begin
      err_cnt_nxt_s = err_cnt_r + {{(ERR_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_nxt_s = err_cnt_r;
    end
  end

  // Stage 2: registered outputs, FSM state and previous-sample tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_bin_r   <= {W{1'b0}};
      state_r      <= ST_ACQUIRE;
      run_r        <= 8'd0;
      bin_out_r    <= {W{1'b0}};
      bin_vld_r    <= 1'b0;
      err_pulse_r  <= 1'b0;
      lost_pulse_r <= 1'b0;
      locked_r     <= 1'b0;
      err_cnt_r    <= {ERR_W{1'b0}};
    end else if (bus.clr) begin
      state_r      <= ST_ACQUIRE;
      run_r        <= 8'd0;
      bin_vld_r    <= 1'b0;
      err_pulse_r  <= 1'b0;
      lost_pulse_r <= 1'b0;
      locked_r     <= 1'b0;
      err_cnt_r    <= {ERR_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      run_r        <= run_nxt_s;
      locked_r     <= locked_nxt_s;
      err_pulse_r  <= err_s;
      lost_pulse_r <= lost_s;
      bin_vld_r    <= s1_vld_r;
      err_cnt_r    <= err_cnt_nxt_s;
      if (s1_vld_r) begin
        bin_out_r  <= bin_s;
        prev_bin_r <= bin_s;
      end
    end
  end

  assign bus.bin_out    = bin_out_r;
  assign bus.bin_vld    = bin_vld_r;
  assign bus.err_pulse  = err_pulse_r;
  assign bus.lost_pulse = lost_pulse_r;
  assign bus.locked     = locked_r;
  assign bus.err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_gray_seq_checker.sv
// Self-checking bench for gray_seq_checker. Two instances share stimulus:
// one with a 16-bit error counter, one with a 4-bit counter to exercise
// saturation. Expectations come from a sample-level model that works on the
// binary values the bench chooses and the step rules (delta mod 256).
module tb_gray_seq_checker;

  localparam int LOCK_CNT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gray_seq_checker_if #(.W(8), .ERR_W(16)) ia ();
  gray_seq_checker_if #(.W(8), .ERR_W(4))  ib ();

  gray_seq_checker #(.W(8), .LOCK_CNT(LOCK_CNT), .ERR_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(ia.slave)
  );
  gray_seq_checker #(.W(8), .LOCK_CNT(LOCK_CNT), .ERR_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(ib.slave)
  );

  // Observed vector: {bin_vld, bin_out, err, lost, locked, err_cnt_a, err_cnt_b}
  logic [31:0] obs_v;
  logic [31:0] exp_v;
  assign obs_v = {ia.bin_vld, ia.bin_out, ia.err_pulse, ia.lost_pulse,
                  ia.locked, ia.err_cnt, ib.err_cnt};

  // Reference model state
  bit m_acq = 1'b1;
  int m_run = 0;
  bit m_locked = 1'b0;
  int m_prev = 0;
  int m_bin = 0;
  int m_cnt_a = 0;
  int m_cnt_b = 0;
  bit e_vld = 1'b0, e_err = 1'b0, e_lost = 1'b0;
  bit pend_vld = 1'b0;
  int pend_bin = 0;

  function automatic logic [7:0] to_gray(input int b);
    logic [7:0] x;
    x = 8'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic model_clear();
    m_acq = 1'b1; m_run = 0; m_locked = 1'b0;
    m_cnt_a = 0; m_cnt_b = 0;
    e_vld = 1'b0; e_err = 1'b0; e_lost = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    m_bin = 0; m_prev = 0; pend_vld = 1'b0;
  endtask

  task automatic model_sample(input bit v, input int b);
    int d;
    e_vld = v; e_err = 1'b0; e_lost = 1'b0;
    if (v) begin
      m_bin = b;
      if (m_acq) begin
        m_acq = 1'b0;
        m_run = 0;
      end else begin
        d = (b - m_prev + 256) % 256;
        if (d == 1) begin
          if (!m_locked) begin
            m_run++;
            if (m_run >= LOCK_CNT) begin
              m_locked = 1'b1;
              m_run = 0;
            end
          end
        end else if (d != 0) begin
          e_err = 1'b1;
          e_lost = m_locked;
          m_locked = 1'b0;
          m_run = 0;
          if (m_cnt_a < 65535) m_cnt_a++;
          if (m_cnt_b < 15) m_cnt_b++;
        end
      end
      m_prev = b;
    end
  endtask

  function automatic logic [31:0] build_exp();
    return {e_vld, 8'(m_bin), e_err, e_lost, m_locked, 16'(m_cnt_a), 4'(m_cnt_b)};
  endfunction

  // Present one sample (binary value b, as Gray) for one clock, then update model.
  task automatic drive(input int b, input bit v, input bit c);
    @(negedge clk);
    ia.gray_in = to_gray(b); ia.gray_vld = v; ia.clr = c;
    ib.gray_in = to_gray(b); ib.gray_vld = v; ib.clr = c;
    @(posedge clk);
    #1;
    if (c) model_clear();
    else   model_sample(pend_vld, pend_bin);
    pend_vld = v && !c;
    pend_bin = b;
    exp_v = build_exp();
  endtask

  task automatic test_reset();
    ia.gray_in = 8'h00; ia.gray_vld = 1'b0; ia.clr = 1'b0;
    ib.gray_in = 8'h00; ib.gray_vld = 1'b0; ib.clr = 1'b0;
    rst = 1'b1;
    model_reset();
    exp_v = build_exp();
    repeat (2) @(negedge clk);
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL reset_state got %h expected %h", obs_v, exp_v);
    end
    rst = 1'b0;
  endtask

  task automatic test_count();
    for (int i = 0; i <= 10; i++) begin
      drive((i < 10) ? i : 9, i < 10, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL count step %0d got %h expected %h", i, obs_v, exp_v);
      end
      if (i == 4 || i == 5) begin
        checks++;
        if (ia.locked !== (i == 5) || ia.bin_out !== 8'(i - 1)) begin
          errors++;
          $display("FAIL lock_rise step %0d got locked %b bin %0d", i, ia.locked, ia.bin_out);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int seq[$] = '{249, 250, 251, 252, 253, 254, 255, 0, 1};
    drive(0, 1'b0, 1'b1);
    for (int k = 0; k <= seq.size(); k++) begin
      drive((k < seq.size()) ? seq[k] : 1, k < seq.size(), 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL wrap step %0d got %h expected %h", k, obs_v, exp_v);
      end
      if (k >= 6) begin
        checks++;
        if (ia.err_pulse !== 1'b0 || ia.locked !== 1'b1) begin
          errors++;
          $display("FAIL wrap_locked step %0d got err %b locked %b", k, ia.err_pulse, ia.locked);
        end
      end
    end
  endtask

  task automatic test_error_relock();
    int seq[$] = '{6, 7, 8, 9, 10, 12, 13, 14, 15, 16};
    drive(0, 1'b0, 1'b1);
    for (int k = 0; k <= seq.size(); k++) begin
      drive((k < seq.size()) ? seq[k] : 16, k < seq.size(), 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL err_relock step %0d got %h expected %h", k, obs_v, exp_v);
      end
      if (k == 6) begin
        checks++;
        if ({ia.err_pulse, ia.lost_pulse, ia.locked} !== 3'b110 || ia.bin_out !== 8'd12 ||
            ia.err_cnt !== 16'd1) begin
          errors++;
          $display("FAIL lost_on_12 got err %b lost %b locked %b bin %0d cnt %0d",
                   ia.err_pulse, ia.lost_pulse, ia.locked, ia.bin_out, ia.err_cnt);
        end
      end
    end
    checks++;
    if (ia.locked !== 1'b1) begin
      errors++;
      $display("FAIL relock_16 got locked %b required 1", ia.locked);
    end
  endtask

  task automatic test_hold();
    int seq[$] = '{2, 3, 4, 5, 5, 5, 6, 7};
    drive(0, 1'b0, 1'b1);
    for (int k = 0; k <= seq.size(); k++) begin
      drive((k < seq.size()) ? seq[k] : 7, k < seq.size(), 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL hold step %0d got %h expected %h", k, obs_v, exp_v);
      end
      if (k >= 4 && k <= 6) begin
        checks++;
        if (ia.err_pulse !== 1'b0 || ia.locked !== 1'b0) begin
          errors++;
          $display("FAIL hold_neutral step %0d got err %b locked %b", k, ia.err_pulse, ia.locked);
        end
      end
    end
  endtask

  task automatic test_saturate();
    drive(0, 1'b0, 1'b1);
    for (int k = 0; k <= 20; k++) begin
      drive((k % 2 == 0) ? 0 : 2, k < 20, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL saturate step %0d got %h expected %h", k, obs_v, exp_v);
      end
    end
    checks++;
    if (ib.err_cnt !== 4'd15 || ia.err_cnt !== 16'd19) begin
      errors++;
      $display("FAIL sat_final got b %0d a %0d required 15 19", ib.err_cnt, ia.err_cnt);
    end
  endtask

  task automatic test_random();
    int cur = 0;
    int r, k;
    bit v, c;
    drive(0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      v = (r < 85);
      c = (r >= 97);
      k = $urandom_range(0, 9);
      if (k < 7)      cur = (cur + 1) % 256;
      else if (k < 9) cur = cur;
      else            cur = $urandom_range(0, 255);
      drive(cur, v, c);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL random step %0d got %h expected %h", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_rst_clr();
    drive(0, 1'b0, 1'b1);
    for (int i = 30; i < 37; i++) begin
      drive(i, 1'b1, 1'b0);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    ia.gray_vld = 1'b0; ib.gray_vld = 1'b0;
    #1;
    model_reset();
    exp_v = build_exp();
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL async_rst got %h expected %h", obs_v, exp_v);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(40 + k, 1'b1, k == 0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL rst_clr step %0d got %h expected %h", k, obs_v, exp_v);
      end
      if (k == 1) begin
        checks++;
        if (ia.bin_vld !== 1'b0) begin
          errors++;
          $display("FAIL clr_drop got bin_vld %b required 0", ia.bin_vld);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_error_relock();
    test_hold();
    test_saturate();
    test_random();
    test_rst_clr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
